// File: rtl/sum_stream_checker.sv
// sum_stream_checker: consumes (a, b, y) triples over valid/ready, accumulates y,
// counts samples and reports a completion summary after NUM_SAMPLES transfers.
// Optional feature macro: SUM_CHECK_EN enables the y == a+b comparator together
// with mismatch_cnt and first_err_idx; without it those outputs are tied to 0.
module sum_stream_checker #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned NUM_SAMPLES = 10,
  parameter int unsigned ACC_W       = 8,
  parameter int unsigned CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_y,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_sum,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic              overflow
);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e           state;
  logic             clear;
  logic             transfer;
  logic [ACC_W:0]   acc_next;
  logic [CNT_W-1:0] cnt_next;

  // Start only counts in IDLE; in_ready is high exactly in COLLECT.
  assign clear    = (state == StIdle) && start;
  assign transfer = in_ready && in_valid;
  // Extra top bit of acc_next is the carry out of the accumulator.
  assign acc_next = {1'b0, acc_sum} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_y};
  assign cnt_next = sample_cnt + CNT_W'(1);

  // Control FSM with registered handshake/status outputs and the accumulator path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      acc_sum    <= '0;
      sample_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            acc_sum    <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            state      <= StCollect;
          end
        end
        StCollect: begin
          if (in_valid) begin
            acc_sum    <= acc_next[ACC_W-1:0];
            sample_cnt <= cnt_next;
            if (acc_next[ACC_W]) begin
              overflow <= 1'b1;
            end
            if (cnt_next == CNT_W'(NUM_SAMPLES)) begin
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= StDone;
            end
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= StIdle;
        end
      endcase
    end
  end

`ifdef SUM_CHECK_EN
  logic [DATA_W-1:0] sum_ab;

  // Truncated to DATA_W so a wrapped adder result is treated as correct.
  assign sum_ab = in_a + in_b;

  // Mismatch counter and index of the first mismatching triple in this run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt  <= '0;
      first_err_idx <= '0;
    end else if (clear) begin
      mismatch_cnt  <= '0;
      first_err_idx <= '0;
    end else if (transfer && (in_y != sum_ab)) begin
      mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      if (mismatch_cnt == '0) begin
        first_err_idx <= sample_cnt;
      end
    end
  end
`else
  logic unused_operands;

  // Operands are only needed by the comparator.
  assign unused_operands = ^{in_a, in_b, transfer};
  assign mismatch_cnt    = '0;
  assign first_err_idx   = '0;
`endif

endmodule

// File: tb/tb_sum_stream_checker.sv
// Self-checking bench for sum_stream_checker. Two instances share the stimulus:
// dut8 uses the default ACC_W=8, dut7 uses ACC_W=7 to exercise accumulator overflow.
// Honours SUM_CHECK_EN for the expected mismatch results.
module tb_sum_stream_checker;

  localparam int N = 10;
`ifdef SUM_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [3:0] in_a, in_b, in_y;

  logic       rdy8, busy8, done8, ovf8;
  logic [7:0] acc8;
  logic [3:0] cnt8, mis8, fei8;
  logic       rdy7, busy7, done7, ovf7;
  logic [6:0] acc7;
  logic [3:0] cnt7, mis7, fei7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_stream_checker #(.DATA_W(4), .NUM_SAMPLES(N), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy8),
    .in_a(in_a), .in_b(in_b), .in_y(in_y), .busy(busy8), .done(done8),
    .acc_sum(acc8), .sample_cnt(cnt8), .mismatch_cnt(mis8), .first_err_idx(fei8),
    .overflow(ovf8)
  );

  sum_stream_checker #(.DATA_W(4), .NUM_SAMPLES(N), .ACC_W(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy7),
    .in_a(in_a), .in_b(in_b), .in_y(in_y), .busy(busy7), .done(done7),
    .acc_sum(acc7), .sample_cnt(cnt7), .mismatch_cnt(mis7), .first_err_idx(fei7),
    .overflow(ovf7)
  );

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Reference model: phase of the run plus the unwrapped total of accepted y values.
  // 0 = idle, 1 = collecting, 2 = done cycle.
  int          m_phase = 0;
  int unsigned m_total = 0;
  int          m_cnt   = 0;
  int          m_mis   = 0;
  int          m_first = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_total = 0; m_cnt = 0; m_mis = 0; m_first = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_total = 0; m_cnt = 0; m_mis = 0; m_first = 0;
        end
        1: if (in_valid) begin
          if (CheckEn && (int'(in_y) != ((int'(in_a) + int'(in_b)) % 16))) begin
            if (m_mis == 0) m_first = m_cnt;
            m_mis++;
          end
          m_total += in_y;
          m_cnt++;
          if (m_cnt == N) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Every-cycle comparison of both instances against the model, away from the edge.
  always @(negedge clk) begin
    chk("in_ready8", int'(rdy8), int'(m_phase == 1));
    chk("busy8", int'(busy8), int'(m_phase == 1));
    chk("done8", int'(done8), int'(m_phase == 2));
    chk("acc_sum8", int'(acc8), int'(m_total % 256));
    chk("overflow8", int'(ovf8), int'(m_total >= 256));
    chk("sample_cnt8", int'(cnt8), m_cnt);
    chk("mismatch_cnt8", int'(mis8), m_mis);
    chk("first_err_idx8", int'(fei8), m_first);
    chk("in_ready7", int'(rdy7), int'(m_phase == 1));
    chk("done7", int'(done7), int'(m_phase == 2));
    chk("acc_sum7", int'(acc7), int'(m_total % 128));
    chk("overflow7", int'(ovf7), int'(m_total >= 128));
    chk("sample_cnt7", int'(cnt7), m_cnt);
    chk("mismatch_cnt7", int'(mis7), m_mis);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int a, input int b, input int y);
    in_valid = 1'b1;
    in_a = 4'(a); in_b = 4'(b); in_y = 4'(y);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, int'(rdy8), 0);
    chk({tag, "_busy"}, int'(busy8), 0);
    chk({tag, "_done"}, int'(done8), 0);
    chk({tag, "_acc"}, int'(acc8), 0);
    chk({tag, "_cnt"}, int'(cnt8), 0);
    chk({tag, "_mis"}, int'(mis8), 0);
    chk({tag, "_fei"}, int'(fei8), 0);
    chk({tag, "_ovf"}, int'(ovf8), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_y = '0;
    #3;
    chk_all_zero("reset");
    #9 rst_n = 1'b1;
    tick();

    // Correct stream: 10 x (3,4,7).
    do_start();
    chk("start_rdy", int'(rdy8), 1);
    for (int i = 0; i < N; i++) send(3, 4, 7);
    in_valid = 1'b0;
    chk("ok_done", int'(done8), 1);
    chk("ok_acc", int'(acc8), 70);
    chk("ok_cnt", int'(cnt8), 10);
    chk("ok_mis", int'(mis8), 0);
    chk("ok_ovf", int'(ovf8), 0);
    chk("ok_rdy_low", int'(rdy8), 0);
    tick();
    chk("ok_done_once", int'(done8), 0);
    chk("ok_hold_acc", int'(acc8), 70);
    tick();

    // Injected errors at indices 3 and 7.
    do_start();
    for (int i = 0; i < N; i++) send(9, 9, (i == 3 || i == 7) ? 5 : 2);
    in_valid = 1'b0;
    chk("err_acc", int'(acc8), 26);
    chk("err_mis", int'(mis8), CheckEn ? 2 : 0);
    chk("err_fei", int'(fei8), CheckEn ? 3 : 0);
    tick(); tick();

    // 4-bit wrap of 9+9 is a correct result.
    do_start();
    for (int i = 0; i < N; i++) send(9, 9, 2);
    in_valid = 1'b0;
    chk("wrap_mis", int'(mis8), 0);
    chk("wrap_acc", int'(acc8), 20);
    tick(); tick();

    // Overflow on the 7-bit accumulator only.
    do_start();
    for (int i = 0; i < N; i++) send(7, 8, 15);
    in_valid = 1'b0;
    chk("ovf7_acc", int'(acc7), 22);
    chk("ovf7_flag", int'(ovf7), 1);
    chk("ovf8_acc", int'(acc8), 150);
    chk("ovf8_flag", int'(ovf8), 0);
    tick(); tick();

    // Gapped valid: one transfer every third cycle, garbage while invalid.
    do_start();
    for (int i = 0; i < N; i++) begin
      send(1, 2, 3);
      in_valid = 1'b0; in_y = 4'd15;
      if (i == N - 1) begin
        chk("gap_done", int'(done8), 1);
        chk("gap_cnt", int'(cnt8), 10);
        chk("gap_acc", int'(acc8), 30);
      end else begin
        tick(); tick();
      end
    end
    tick(); tick();

    // Mid-run reset after 5 transfers, then a clean run.
    do_start();
    for (int i = 0; i < 5; i++) send(3, 4, 7);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    rst_n = 1'b1;
    tick();
    do_start();
    for (int i = 0; i < N; i++) send(2, 2, 4);
    in_valid = 1'b0;
    chk("after_rst_acc", int'(acc8), 40);
    chk("after_rst_cnt", int'(cnt8), 10);
    chk("after_rst_mis", int'(mis8), 0);
    tick(); tick();

    // Start pulsed during the run is ignored.
    do_start();
    for (int i = 0; i < N; i++) begin
      start = (i == 4);
      send(1, 1, 2);
    end
    start = 1'b0; in_valid = 1'b0;
    chk("busy_start_done", int'(done8), 1);
    chk("busy_start_cnt", int'(cnt8), 10);
    chk("busy_start_acc", int'(acc8), 20);
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_stream_checker.md
# sum_stream_checker

Downstream consumer for the 4-bit adder stage. It accepts a stream of operand/result triples (a, b, y) over a valid/ready handshake and checks each y against (a + b) mod 2^DATA_W. It also accumulates the y values and counts samples, then reports a completion summary after a programmed number of samples. It replaces ad-hoc per-cycle $display checking with a synthesizable, self-counting checker that a bench or an on-chip BIST wrapper can read.

## Interface
- DATA_W, 4, width of a, b, y
- NUM_SAMPLES, 10, triples collected per run (>= 1)
- ACC_W, 8, accumulator width; wraps modulo 2^ACC_W
- CNT_W, $clog2(NUM_SAMPLES+1), width of counters/indices (derived)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- in_valid  in  1  triple on in_a/in_b/in_y is valid
- in_ready  out  1  checker can accept a triple
- in_a  in  DATA_W  operand a
- in_b  in  DATA_W  operand b
- in_y  in  DATA_W  result from adder stage
- busy  out  1  high in COLLECT
- done  out  1  one-cycle pulse when a run completes
- acc_sum  out  ACC_W  running sum of accepted in_y
- sample_cnt  out  CNT_W  triples accepted this run
- mismatch_cnt  out  CNT_W  triples with in_y != (in_a+in_b) mod 2^DATA_W
- first_err_idx  out  CNT_W  zero-based index of first mismatch (valid when mismatch_cnt != 0)
- overflow  out  1  sticky; set on any accumulator carry-out this run

## Operation
- FSM states: IDLE, COLLECT, DONE.
- IDLE: in_ready=0, busy=0. When start=1, clear acc_sum, sample_cnt, mismatch_cnt, first_err_idx and overflow, then go to COLLECT.
- COLLECT: in_ready=1, busy=1. A transfer happens when in_valid && in_ready on a rising edge. On each transfer:
  - acc_sum += in_y (zero-extended). A carry out of ACC_W sets overflow.
  - Compare in_y with the DATA_W-bit sum of in_a and in_b. On mismatch, increment mismatch_cnt. If mismatch_cnt was 0, load first_err_idx with the current sample_cnt.
  - Increment sample_cnt.
  - If the transfer makes sample_cnt == NUM_SAMPLES, go to DONE.
- DONE: lasts one cycle. done=1, in_ready=0, then go to IDLE.
- Result outputs hold their values in IDLE until the next start.
- start is ignored in COLLECT and DONE.
- When in_valid=0, nothing changes and the FSM stays in COLLECT. There is no timeout.
- Reset values: in_ready=0, busy=0, done=0, acc_sum=0, sample_cnt=0, mismatch_cnt=0, first_err_idx=0, overflow=0, FSM=IDLE.
- Asserting rst_n low at any time, including mid-run, forces all reset values immediately. Partial results are discarded.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- start sampled high at edge N: in_ready=1 and busy=1 from edge N onward, so the first transfer can occur at edge N+1.
- A transfer at edge T: acc_sum, sample_cnt, mismatch_cnt and overflow are updated after edge T.
- Final transfer at edge T: done=1 and in_ready=0 for the cycle after T. IDLE resumes at T+1. The earliest restart is start sampled at edge T+2.
- Back-to-back transfers are sustained at one per cycle in COLLECT.
- Minimum run length is NUM_SAMPLES+2 cycles from start to return to IDLE.

## Configuration
- SUM_CHECK_EN defined: comparator, mismatch_cnt and first_err_idx are implemented as described.
- SUM_CHECK_EN undefined: the comparator is removed, mismatch_cnt and first_err_idx are tied to 0, and in_a/in_b are unused. Accumulation, counting, handshake and FSM are unchanged.

## Test plan
- Correct stream: start, then 10 back-to-back triples a=3, b=4, y=7 -> acc_sum=70, sample_cnt=10, mismatch_cnt=0, overflow=0, done pulses exactly one cycle after the 10th transfer.
- Injected error (SUM_CHECK_EN defined): 10 triples a=9, b=9, y=2, with triples 3 and 7 (zero-based) given y=5 -> mismatch_cnt=2, first_err_idx=3, acc_sum=26. Also run with y=2 everywhere to confirm the 4-bit wrap is treated as correct: mismatch_cnt=0.
- Overflow: ACC_W=7, 10 triples with y=15 -> acc_sum=22 (150 mod 128), overflow=1.
- Gapped valid: in_valid asserted every third cycle with a=1, b=2, y=3 -> only handshakes count, sample_cnt=10, acc_sum=30, done one cycle after the last transfer.
- Mid-run reset: rst_n pulsed low after 5 transfers -> all outputs 0 and FSM in IDLE immediately. A new start and 10 triples then yields a clean result.
- Start while busy: start pulsed at transfer 4 -> ignored; counters are not cleared and the run completes normally at 10 transfers.
